// File: rtl/hazard_pkg.sv
// Shared definitions for the pipeline hazard controller.
//   state_e          : controller state (RUN, DIV_WAIT, MEM_WAIT)
//   DIV_LATENCY_DEF  : default cycles a divide occupies EX
//   MEM_TIMEOUT_DEF  : default consecutive wait cycles before mem_timeout
//   REG_X0           : architectural zero register index
package hazard_pkg;

    typedef enum logic [1:0] {
        RUN      = 2'd0,
        DIV_WAIT = 2'd1,
        MEM_WAIT = 2'd2
    } state_e;

    localparam int DIV_LATENCY_DEF = 4;
    localparam int MEM_TIMEOUT_DEF = 64;

    localparam logic [4:0] REG_X0 = 5'd0;

endpackage

// File: rtl/load_use_detect.sv
// Combinational load-use hazard comparator.
// Ports:
//   id_rs1, id_rs2           : source registers of the ID instruction
//   id_uses_rs1, id_uses_rs2 : ID instruction really reads that source
//   ex_rd                    : destination of the EX instruction
//   ex_mem_read              : EX instruction is a load
//   hazard                   : ID needs the load result before it exists
module load_use_detect
    import hazard_pkg::*;
(
    input  logic [4:0] id_rs1,
    input  logic [4:0] id_rs2,
    input  logic       id_uses_rs1,
    input  logic       id_uses_rs2,
    input  logic [4:0] ex_rd,
    input  logic       ex_mem_read,
    output logic       hazard
);

    // x0 never carries a real value, so a load "into" x0 cannot be a hazard.
    assign hazard = ex_mem_read && (ex_rd != REG_X0) &&
                    ((id_uses_rs1 && (id_rs1 == ex_rd)) ||
                     (id_uses_rs2 && (id_rs2 == ex_rd)));

endmodule

// File: rtl/hazard_ctrl.sv
// Pipeline hazard controller for the 5-stage core.
// Drives the write enables and flushes of PC, IF_ID, ID_EX and EX_MEM.
// Ports:
//   clk, reset                        : clock, synchronous active-high reset
//   id_rs1/2, id_uses_rs1/2           : ID source operands
//   ex_rd, ex_mem_read, ex_is_div     : EX instruction info
//   branch_taken                      : EX resolved a taken branch/jump
//   mem_access, dmem_ready            : MEM data access handshake
//   pc_write .. ex_mem_write          : register enables
//   if_id_flush, id_ex_flush          : load NOP into register at next edge
//   div_done                          : divide release cycle
//   mem_timeout                       : sticky memory-wait timeout flag
//   stall_cycles                      : saturating count of pc_write=0 cycles
module hazard_ctrl
    import hazard_pkg::*;
#(
    parameter int DIV_LATENCY = DIV_LATENCY_DEF,
    parameter int MEM_TIMEOUT = MEM_TIMEOUT_DEF
) (
    input  logic        clk,
    input  logic        reset,
    input  logic [4:0]  id_rs1,
    input  logic [4:0]  id_rs2,
    input  logic        id_uses_rs1,
    input  logic        id_uses_rs2,
    input  logic [4:0]  ex_rd,
    input  logic        ex_mem_read,
    input  logic        ex_is_div,
    input  logic        branch_taken,
    input  logic        mem_access,
    input  logic        dmem_ready,
    output logic        pc_write,
    output logic        if_id_write,
    output logic        id_ex_write,
    output logic        ex_mem_write,
    output logic        if_id_flush,
    output logic        id_ex_flush,
    output logic        div_done,
    output logic        mem_timeout,
    output logic [15:0] stall_cycles
);

    // The entry cycle in RUN is the first stall cycle, so the countdown
    // starts two below the latency and the release happens when it hits zero.
    localparam logic [7:0]  DIV_INIT = 8'(DIV_LATENCY - 2);
    localparam logic [15:0] MEM_TO   = 16'(MEM_TIMEOUT);

    state_e      state_q, state_d;
    logic [7:0]  divcnt_q, divcnt_d;
    logic [15:0] wait_q, wait_d;
    logic        mem_timeout_q, mem_timeout_d;
    logic [15:0] stall_q, stall_d;

    logic memstall;
    logic load_use;

    assign memstall = mem_access && !dmem_ready;

    load_use_detect u_load_use (
        .id_rs1      (id_rs1),
        .id_rs2      (id_rs2),
        .id_uses_rs1 (id_uses_rs1),
        .id_uses_rs2 (id_uses_rs2),
        .ex_rd       (ex_rd),
        .ex_mem_read (ex_mem_read),
        .hazard      (load_use)
    );

    always_comb begin
        pc_write      = 1'b1;
        if_id_write   = 1'b1;
        id_ex_write   = 1'b1;
        ex_mem_write  = 1'b1;
        if_id_flush   = 1'b0;
        id_ex_flush   = 1'b0;
        div_done      = 1'b0;
        state_d       = state_q;
        divcnt_d      = divcnt_q;
        wait_d        = 16'd0;      // counts consecutive waits only
        mem_timeout_d = mem_timeout_q;

        unique case (state_q)
            DIV_WAIT: begin
                if (divcnt_q != 8'd0) begin
                    divcnt_d = divcnt_q - 8'd1;
                end
                if ((divcnt_q == 8'd0) && !memstall) begin
                    div_done = 1'b1;
                    state_d  = RUN;
                end else begin
                    pc_write     = 1'b0;
                    if_id_write  = 1'b0;
                    id_ex_write  = 1'b0;
                    ex_mem_write = 1'b0;
                end
            end
            // RUN and MEM_WAIT share the rule chain; MEM_WAIT only differs in
            // that an ongoing stall keeps counting instead of restarting at 1.
            default: begin
                if (memstall) begin
                    pc_write     = 1'b0;
                    if_id_write  = 1'b0;
                    id_ex_write  = 1'b0;
                    ex_mem_write = 1'b0;
                    state_d      = MEM_WAIT;
                    if (state_q == MEM_WAIT) begin
                        wait_d = (wait_q == 16'hFFFF) ? wait_q : wait_q + 16'd1;
                    end else begin
                        wait_d = 16'd1;
                    end
                    if (wait_d >= MEM_TO) begin
                        mem_timeout_d = 1'b1;
                    end
                end else if (ex_is_div) begin
                    pc_write     = 1'b0;
                    if_id_write  = 1'b0;
                    id_ex_write  = 1'b0;
                    ex_mem_write = 1'b0;
                    divcnt_d     = DIV_INIT;
                    state_d      = DIV_WAIT;
                end else if (branch_taken) begin
                    if_id_flush = 1'b1;
                    id_ex_flush = 1'b1;
                    state_d     = RUN;
                end else if (load_use) begin
                    // Hold PC and IF_ID, inject a bubble into ID_EX, and let
                    // the load advance into MEM.
                    pc_write    = 1'b0;
                    if_id_write = 1'b0;
                    id_ex_flush = 1'b1;
                    state_d     = RUN;
                end else begin
                    state_d = RUN;
                end
            end
        endcase

        if (reset) begin
            pc_write     = 1'b0;
            if_id_write  = 1'b0;
            id_ex_write  = 1'b0;
            ex_mem_write = 1'b0;
            if_id_flush  = 1'b1;
            id_ex_flush  = 1'b1;
            div_done     = 1'b0;
        end

        stall_d = stall_q;
        if (!pc_write && (stall_q != 16'hFFFF)) begin
            stall_d = stall_q + 16'd1;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q       <= RUN;
            divcnt_q      <= 8'd0;
            wait_q        <= 16'd0;
            mem_timeout_q <= 1'b0;
            stall_q       <= 16'd0;
        end else begin
            state_q       <= state_d;
            divcnt_q      <= divcnt_d;
            wait_q        <= wait_d;
            mem_timeout_q <= mem_timeout_d;
            stall_q       <= stall_d;
        end
    end

    assign mem_timeout  = mem_timeout_q;
    assign stall_cycles = stall_q;

endmodule

// File: tb/tb_hazard_ctrl.sv
module tb_hazard_ctrl;

    // {pc, if_id, id_ex, ex_mem, if_id_flush, id_ex_flush, div_done}
    typedef struct packed {
        logic pc;
        logic ifid;
        logic idex;
        logic exmem;
        logic fl_ifid;
        logic fl_idex;
        logic dd;
    } ctrl_t;

    typedef struct packed {
        logic [4:0] rs1;
        logic [4:0] rs2;
        logic       u1;
        logic       u2;
        logic [4:0] rd;
        logic       mr;
        logic       br;
        logic       ma;
        logic       rdy;
        ctrl_t      exp;
    } vec_t;

    typedef struct {
        string       name;
        ctrl_t       ctrl;
        logic [15:0] stall;
        logic        to1;
    } exp_t;

    localparam ctrl_t C_RUN = 7'b1111_00_0;
    localparam ctrl_t C_LU  = 7'b0011_01_0;
    localparam ctrl_t C_BR  = 7'b1111_11_0;
    localparam ctrl_t C_FRZ = 7'b0000_00_0;
    localparam ctrl_t C_REL = 7'b1111_00_1;
    localparam ctrl_t C_RST = 7'b0000_11_0;

    logic       clk = 1'b0;
    logic       reset = 1'b1;
    logic [4:0] id_rs1 = '0, id_rs2 = '0, ex_rd = '0;
    logic       id_uses_rs1 = 0, id_uses_rs2 = 0, ex_mem_read = 0, ex_is_div = 0;
    logic       branch_taken = 0, mem_access = 0, dmem_ready = 0;

    logic        pc_write, if_id_write, id_ex_write, ex_mem_write;
    logic        if_id_flush, id_ex_flush, div_done, mem_timeout;
    logic [15:0] stall_cycles;
    logic        pc_write_b, if_id_write_b, id_ex_write_b, ex_mem_write_b;
    logic        if_id_flush_b, id_ex_flush_b, div_done_b, mem_timeout_b;
    logic [15:0] stall_cycles_b;

    exp_t        sb_q[$];
    int          n_checks = 0;
    int          n_fail = 0;
    logic [15:0] exp_stall = '0;
    logic        exp_to1 = 1'b0;
    vec_t        vecs[9];
    string       vnames[9];

    always #5 clk = ~clk;

    hazard_ctrl dut (
        .clk(clk), .reset(reset),
        .id_rs1(id_rs1), .id_rs2(id_rs2),
        .id_uses_rs1(id_uses_rs1), .id_uses_rs2(id_uses_rs2),
        .ex_rd(ex_rd), .ex_mem_read(ex_mem_read), .ex_is_div(ex_is_div),
        .branch_taken(branch_taken), .mem_access(mem_access), .dmem_ready(dmem_ready),
        .pc_write(pc_write), .if_id_write(if_id_write),
        .id_ex_write(id_ex_write), .ex_mem_write(ex_mem_write),
        .if_id_flush(if_id_flush), .id_ex_flush(id_ex_flush),
        .div_done(div_done), .mem_timeout(mem_timeout), .stall_cycles(stall_cycles)
    );

    // Same stimulus, short timeout, to exercise the sticky flag.
    hazard_ctrl #(.DIV_LATENCY(4), .MEM_TIMEOUT(3)) dut_to3 (
        .clk(clk), .reset(reset),
        .id_rs1(id_rs1), .id_rs2(id_rs2),
        .id_uses_rs1(id_uses_rs1), .id_uses_rs2(id_uses_rs2),
        .ex_rd(ex_rd), .ex_mem_read(ex_mem_read), .ex_is_div(ex_is_div),
        .branch_taken(branch_taken), .mem_access(mem_access), .dmem_ready(dmem_ready),
        .pc_write(pc_write_b), .if_id_write(if_id_write_b),
        .id_ex_write(id_ex_write_b), .ex_mem_write(ex_mem_write_b),
        .if_id_flush(if_id_flush_b), .id_ex_flush(id_ex_flush_b),
        .div_done(div_done_b), .mem_timeout(mem_timeout_b), .stall_cycles(stall_cycles_b)
    );

    task automatic check_front();
        exp_t  e;
        ctrl_t got;
        e   = sb_q.pop_front();
        got = {pc_write, if_id_write, id_ex_write, ex_mem_write,
               if_id_flush, id_ex_flush, div_done};
        n_checks++;
        if (got !== e.ctrl) begin
            n_fail++;
            $display("FAIL %s ctrl: got %b required %b", e.name, got, e.ctrl);
        end
        n_checks++;
        if (stall_cycles !== e.stall) begin
            n_fail++;
            $display("FAIL %s stall_cycles: got %0d required %0d", e.name, stall_cycles, e.stall);
        end
        n_checks++;
        if ({mem_timeout, mem_timeout_b} !== {1'b0, e.to1}) begin
            n_fail++;
            $display("FAIL %s mem_timeout(64,3): got %b%b required 0%b",
                     e.name, mem_timeout, mem_timeout_b, e.to1);
        end
        $display("txn %-14s ctrl=%b stall=%0d timeout=%b%b",
                 e.name, got, stall_cycles, mem_timeout, mem_timeout_b);
    endtask

    // Inputs are already driven; queue the expectation, sample at negedge,
    // then advance the model to what the registers hold after the edge.
    task automatic expect_cycle(input string nm, input ctrl_t c);
        exp_t e;
        e.name  = nm;
        e.ctrl  = c;
        e.stall = exp_stall;
        e.to1   = exp_to1;
        sb_q.push_back(e);
        if (reset) begin
            exp_stall = '0;
            exp_to1   = 1'b0;
        end else if (!c.pc && exp_stall != 16'hFFFF) begin
            exp_stall = exp_stall + 16'd1;
        end
        @(negedge clk);
        check_front();
        @(posedge clk);
        #1;
    endtask

    task automatic idle_inputs();
        id_rs1 = '0; id_rs2 = '0; id_uses_rs1 = 0; id_uses_rs2 = 0;
        ex_rd = '0; ex_mem_read = 0; ex_is_div = 0; branch_taken = 0;
        mem_access = 0; dmem_ready = 0;
    endtask

    initial begin
        //             rs1   rs2   u1    u2    rd    mr    br    ma    rdy   expected
        vecs[0] = {5'd1, 5'd2, 1'b1, 1'b1, 5'd1, 1'b0, 1'b0, 1'b0, 1'b0, C_RUN}; vnames[0] = "addi_add";
        vecs[1] = {5'd5, 5'd0, 1'b1, 1'b0, 5'd5, 1'b1, 1'b0, 1'b0, 1'b0, C_LU};  vnames[1] = "lw_use_rs1";
        vecs[2] = {5'd5, 5'd0, 1'b1, 1'b0, 5'd3, 1'b0, 1'b0, 1'b0, 1'b0, C_RUN}; vnames[2] = "after_lu";
        vecs[3] = {5'd0, 5'd0, 1'b1, 1'b1, 5'd0, 1'b1, 1'b0, 1'b0, 1'b0, C_RUN}; vnames[3] = "lw_x0";
        vecs[4] = {5'd3, 5'd7, 1'b1, 1'b1, 5'd7, 1'b1, 1'b0, 1'b0, 1'b0, C_LU};  vnames[4] = "lw_use_rs2";
        vecs[5] = {5'd3, 5'd7, 1'b1, 1'b0, 5'd7, 1'b1, 1'b0, 1'b0, 1'b0, C_RUN}; vnames[5] = "rs2_unused";
        vecs[6] = {5'd0, 5'd0, 1'b0, 1'b0, 5'd0, 1'b0, 1'b1, 1'b0, 1'b0, C_BR};  vnames[6] = "branch";
        vecs[7] = {5'd9, 5'd0, 1'b1, 1'b0, 5'd9, 1'b1, 1'b1, 1'b0, 1'b0, C_BR};  vnames[7] = "branch_lu";
        vecs[8] = {5'd0, 5'd0, 1'b0, 1'b0, 5'd0, 1'b0, 1'b0, 1'b1, 1'b1, C_RUN}; vnames[8] = "mem_ready";

        idle_inputs();
        reset = 1'b1;
        @(posedge clk);
        #1;
        expect_cycle("reset", C_RST);
        reset = 1'b0;

        for (int i = 0; i < 9; i++) begin
            id_rs1 = vecs[i].rs1; id_rs2 = vecs[i].rs2;
            id_uses_rs1 = vecs[i].u1; id_uses_rs2 = vecs[i].u2;
            ex_rd = vecs[i].rd; ex_mem_read = vecs[i].mr;
            branch_taken = vecs[i].br; mem_access = vecs[i].ma; dmem_ready = vecs[i].rdy;
            expect_cycle(vnames[i], vecs[i].exp);
        end
        idle_inputs();

        // Divide: DIV_LATENCY-1 frozen cycles, then the release cycle.
        ex_is_div = 1'b1;
        for (int i = 0; i < 3; i++) expect_cycle("div_stall", C_FRZ);
        expect_cycle("div_release", C_REL);
        ex_is_div = 1'b0;
        expect_cycle("after_div", C_RUN);

        // Five wait cycles; the short-timeout instance trips on the third.
        mem_access = 1'b1;
        dmem_ready = 1'b0;
        for (int i = 0; i < 5; i++) begin
            if (i == 3) exp_to1 = 1'b1;
            expect_cycle("mem_wait", C_FRZ);
        end
        dmem_ready = 1'b1;
        expect_cycle("mem_release", C_RUN);
        idle_inputs();
        expect_cycle("after_mem", C_RUN);

        // Memstall with a held branch: freeze, then the branch on release.
        branch_taken = 1'b1;
        mem_access   = 1'b1;
        dmem_ready   = 1'b0;
        expect_cycle("memstall_br", C_FRZ);
        expect_cycle("memstall_br", C_FRZ);
        dmem_ready = 1'b1;
        expect_cycle("br_on_release", C_BR);
        idle_inputs();
        expect_cycle("after_br", C_RUN);

        // Reset during the second DIV_WAIT cycle aborts the divide.
        ex_is_div = 1'b1;
        expect_cycle("div_enter", C_FRZ);
        expect_cycle("div_wait1", C_FRZ);
        reset = 1'b1;
        expect_cycle("reset_in_div", C_RST);
        reset = 1'b0;
        ex_is_div = 1'b0;
        expect_cycle("post_reset", C_RUN);
        expect_cycle("post_reset2", C_RUN);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
